bus_master_arb: RTL and testbench

Arbitrates the shared system bus among four bus masters and drives the selected master's request signals onto the common slave side. It is the master-to-slave counterpart of the slave-to-master read-data/ready multiplexer. The block holds a registered bus owner, generates one-hot active-low grants, and multiplexes address, strobe, read/write and write data from the owner to the address decoder and all slaves.

---
 rtl/bus_master_arb_pkg.sv | 22 ++
 rtl/bus_master_mux.sv | 58 +++++
 rtl/bus_master_arb.sv | 105 ++++++++++
 tb/tb_bus_master_arb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bus_master_arb_pkg.sv
// Shared bus definitions for the four-master system bus: widths, active-low
// enable levels, read/write encoding and bus-owner encodings.
package bus_master_arb_pkg;

  localparam int WORD_ADDR_W   = 30;
  localparam int WORD_DATA_W   = 32;
  localparam int BUS_OWNER_W   = 2;
  localparam int BUS_MASTER_CH = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [BUS_OWNER_W-1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_e;

endpackage

// File: rtl/bus_master_mux.sv
// Combinational master-to-slave multiplexer: routes the current bus owner's
// address, strobe, read/write and write data onto the shared slave side.
module bus_master_mux
  import bus_master_arb_pkg::*;
(
  input  bus_owner_e              owner,
  input  logic [WORD_ADDR_W-1:0]  m0_addr,
  input  logic                    m0_as_,
  input  logic                    m0_rw,
  input  logic [WORD_DATA_W-1:0]  m0_wr_data,
  input  logic [WORD_ADDR_W-1:0]  m1_addr,
  input  logic                    m1_as_,
  input  logic                    m1_rw,
  input  logic [WORD_DATA_W-1:0]  m1_wr_data,
  input  logic [WORD_ADDR_W-1:0]  m2_addr,
  input  logic                    m2_as_,
  input  logic                    m2_rw,
  input  logic [WORD_DATA_W-1:0]  m2_wr_data,
  input  logic [WORD_ADDR_W-1:0]  m3_addr,
  input  logic                    m3_as_,
  input  logic                    m3_rw,
  input  logic [WORD_DATA_W-1:0]  m3_wr_data,
  output logic [WORD_ADDR_W-1:0]  s_addr,
  output logic                    s_as_,
  output logic                    s_rw,
  output logic [WORD_DATA_W-1:0]  s_wr_data
);

  // No gating: an idle owner is expected to hold its own as_ negated.
  always_comb begin
    s_addr    = m0_addr;
    s_as_     = m0_as_;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    case (owner)
      BUS_OWNER_MASTER_1: begin
        s_addr    = m1_addr;
        s_as_     = m1_as_;
        s_rw      = m1_rw;
        s_wr_data = m1_wr_data;
      end
      BUS_OWNER_MASTER_2: begin
        s_addr    = m2_addr;
        s_as_     = m2_as_;
        s_rw      = m2_rw;
        s_wr_data = m2_wr_data;
      end
      BUS_OWNER_MASTER_3: begin
        s_addr    = m3_addr;
        s_as_     = m3_as_;
        s_rw      = m3_rw;
        s_wr_data = m3_wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_master_arb.sv
// Four-master bus arbiter: registered owner, one-hot active-low grants and
// owner-driven slave-side mux. Define BUS_ARB_ROUND_ROBIN_EN for round-robin;
// otherwise fixed priority m0 > m1 > m2 > m3.
module bus_master_arb
  import bus_master_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req_,
  input  logic [WORD_ADDR_W-1:0]  m0_addr,
  input  logic                    m0_as_,
  input  logic                    m0_rw,
  input  logic [WORD_DATA_W-1:0]  m0_wr_data,
  output logic                    m0_grnt_,
  input  logic                    m1_req_,
  input  logic [WORD_ADDR_W-1:0]  m1_addr,
  input  logic                    m1_as_,
  input  logic                    m1_rw,
  input  logic [WORD_DATA_W-1:0]  m1_wr_data,
  output logic                    m1_grnt_,
  input  logic                    m2_req_,
  input  logic [WORD_ADDR_W-1:0]  m2_addr,
  input  logic                    m2_as_,
  input  logic                    m2_rw,
  input  logic [WORD_DATA_W-1:0]  m2_wr_data,
  output logic                    m2_grnt_,
  input  logic                    m3_req_,
  input  logic [WORD_ADDR_W-1:0]  m3_addr,
  input  logic                    m3_as_,
  input  logic                    m3_rw,
  input  logic [WORD_DATA_W-1:0]  m3_wr_data,
  output logic                    m3_grnt_,
  output logic [WORD_ADDR_W-1:0]  s_addr,
  output logic                    s_as_,
  output logic                    s_rw,
  output logic [WORD_DATA_W-1:0]  s_wr_data
);

  bus_owner_e                owner;
  logic [BUS_MASTER_CH-1:0]  req;

  assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

  // Only consulted once the current owner has released; returns cur when
  // nobody else is asking so the bus parks on the last master.
  function automatic bus_owner_e pick_owner(input bus_owner_e cur,
                                            input logic [BUS_MASTER_CH-1:0] rq);
    bus_owner_e nxt;
    nxt = cur;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int i = BUS_MASTER_CH - 1; i >= 1; i--) begin
      logic [BUS_OWNER_W-1:0] idx;
      idx = cur + BUS_OWNER_W'(i);
      if (rq[idx]) nxt = bus_owner_e'(idx);
    end
`else
    begin
      logic [BUS_MASTER_CH-1:0] cand;
      cand = rq & ~(BUS_MASTER_CH'(1) << cur);
      for (int i = BUS_MASTER_CH - 1; i >= 0; i--) begin
        if (cand[i]) nxt = bus_owner_e'(BUS_OWNER_W'(i));
      end
    end
`endif
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= BUS_OWNER_MASTER_0;
    end else if (req[owner] != 1'b1) begin
      owner <= pick_owner(owner, req);
    end
  end

  assign m0_grnt_ = (owner == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
  assign m1_grnt_ = (owner == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
  assign m2_grnt_ = (owner == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
  assign m3_grnt_ = (owner == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;

  bus_master_mux u_mux (
    .owner      (owner),
    .m0_addr    (m0_addr),
    .m0_as_     (m0_as_),
    .m0_rw      (m0_rw),
    .m0_wr_data (m0_wr_data),
    .m1_addr    (m1_addr),
    .m1_as_     (m1_as_),
    .m1_rw      (m1_rw),
    .m1_wr_data (m1_wr_data),
    .m2_addr    (m2_addr),
    .m2_as_     (m2_as_),
    .m2_rw      (m2_rw),
    .m2_wr_data (m2_wr_data),
    .m3_addr    (m3_addr),
    .m3_as_     (m3_as_),
    .m3_rw      (m3_rw),
    .m3_wr_data (m3_wr_data),
    .s_addr     (s_addr),
    .s_as_      (s_as_),
    .s_rw       (s_rw),
    .s_wr_data  (s_wr_data)
  );

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed bench for bus_master_arb; expected grants follow the policy
// selected by BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_master_arb;
  import bus_master_arb_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   m0_req_, m1_req_, m2_req_, m3_req_;
  logic [WORD_ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
  logic                   m0_as_, m1_as_, m2_as_, m3_as_;
  logic                   m0_rw, m1_rw, m2_rw, m3_rw;
  logic [WORD_DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
  logic                   m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [WORD_ADDR_W-1:0] s_addr;
  logic                   s_as_;
  logic                   s_rw;
  logic [WORD_DATA_W-1:0] s_wr_data;
  logic [3:0]             gnt;

  int errs   = 0;
  int checks = 0;

  assign gnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  always #5 clk = ~clk;

  bus_master_arb dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req_    (m0_req_),
    .m0_addr    (m0_addr),
    .m0_as_     (m0_as_),
    .m0_rw      (m0_rw),
    .m0_wr_data (m0_wr_data),
    .m0_grnt_   (m0_grnt_),
    .m1_req_    (m1_req_),
    .m1_addr    (m1_addr),
    .m1_as_     (m1_as_),
    .m1_rw      (m1_rw),
    .m1_wr_data (m1_wr_data),
    .m1_grnt_   (m1_grnt_),
    .m2_req_    (m2_req_),
    .m2_addr    (m2_addr),
    .m2_as_     (m2_as_),
    .m2_rw      (m2_rw),
    .m2_wr_data (m2_wr_data),
    .m2_grnt_   (m2_grnt_),
    .m3_req_    (m3_req_),
    .m3_addr    (m3_addr),
    .m3_as_     (m3_as_),
    .m3_rw      (m3_rw),
    .m3_wr_data (m3_wr_data),
    .m3_grnt_   (m3_grnt_),
    .s_addr     (s_addr),
    .s_as_      (s_as_),
    .s_rw       (s_rw),
    .s_wr_data  (s_wr_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant pattern {g3,g2,g1,g0} for a given owner index.
  function automatic logic [3:0] gpat(input int n);
    return ~(4'b0001 << n);
  endfunction

  task automatic set_req(input logic [3:0] r);
    {m3_req_, m2_req_, m1_req_, m0_req_} = ~r;
  endtask

  int exp_seq[5];
  int cur;

  initial begin
    reset = 1'b0;
    set_req(4'b0000);
    m0_addr = 30'h10;  m0_as_ = 1'b1; m0_rw = READ;  m0_wr_data = 32'h0000_0000;
    m1_addr = 30'h11;  m1_as_ = 1'b1; m1_rw = READ;  m1_wr_data = 32'h1111_1111;
    m2_addr = 30'h2A;  m2_as_ = 1'b0; m2_rw = WRITE; m2_wr_data = 32'hDEAD_BEEF;
    m3_addr = 30'h33;  m3_as_ = 1'b1; m3_rw = READ;  m3_wr_data = 32'h3333_3333;

    // Test 1: reset state and parking on master 0
    #12;
    chk("rst_gnt", 32'(gnt), 32'(4'b1110));
    chk("rst_saddr", 32'(s_addr), 32'h10);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'(4'b1110));
    end

    // Test 2: lone request from m2, then park
    set_req(4'b0100);
    step();
    chk("m2_gnt", 32'(gnt), 32'(gpat(2)));
    chk("m2_saddr", 32'(s_addr), 32'h2A);
    chk("m2_srw", 32'(s_rw), 32'(WRITE));
    chk("m2_sdata", s_wr_data, 32'hDEAD_BEEF);
    chk("m2_sas", 32'(s_as_), 32'(1'b0));
    set_req(4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m2_park", 32'(gnt), 32'(gpat(2)));
    end

    // Test 3: m1 holds the bus against m0/m3, then releases
    set_req(4'b0010);
    step();
    chk("m1_gnt", 32'(gnt), 32'(gpat(1)));
    set_req(4'b1011);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("m1_hold", 32'(gnt), 32'(gpat(1)));
    end
    set_req(4'b1001);
    step();
`ifdef BUS_ARB_ROUND_ROBIN_EN
    chk("m1_handover", 32'(gnt), 32'(gpat(3)));
    chk("handover_saddr", 32'(s_addr), 32'h33);
`else
    chk("m1_handover", 32'(gnt), 32'(gpat(0)));
    chk("handover_saddr", 32'(s_addr), 32'h10);
`endif

    // Test 4: everybody requests; each owner drops req for one cycle
    set_req(4'b0000);
    reset = 1'b0;
    #2;
    reset = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 2, 3, 0, 1};
`else
    exp_seq = '{1, 0, 1, 0, 1};
`endif
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      set_req(4'b1111 & ~(4'b0001 << cur));
      step();
      chk("rotate_gnt", 32'(gnt), 32'(gpat(exp_seq[i])));
      cur = exp_seq[i];
    end

    // Test 5: asynchronous reset while m3 is mid-transfer
    set_req(4'b1000);
    step();
    chk("m3_gnt", 32'(gnt), 32'(gpat(3)));
    m3_as_ = 1'b0;
    #1;
    chk("m3_sas", 32'(s_as_), 32'(1'b0));
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'(4'b1110));
    chk("async_rst_saddr", 32'(s_addr), 32'h10);
    m3_as_ = 1'b1;
    set_req(4'b0000);
    #1;
    reset = 1'b1;
    step();
    chk("post_rst_park", 32'(gnt), 32'(4'b1110));
    set_req(4'b1000);
    step();
    chk("m3_retry_gnt", 32'(gnt), 32'(gpat(3)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
